// File: rtl/alu_issue_pkg.sv
// rtl/alu_issue_pkg.sv - shared types and constants for the ALU issue unit
package alu_issue_pkg;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ISSUE   = 2'd1,
        S_CAPTURE = 2'd2,
        S_RESP    = 2'd3
    } state_t;

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_AND = 4'd2;
    localparam logic [3:0] OP_OR  = 4'd3;
    localparam logic [3:0] OP_NOT = 4'd4;
    localparam logic [3:0] OP_XOR = 4'd5;
    localparam logic [3:0] OP_SHL = 4'd6;
    localparam logic [3:0] OP_SHR = 4'd7;
    localparam logic [3:0] OP_SRA = 4'd8;
    localparam logic [3:0] OP_MAX = 4'd8;

    // Bit positions inside the {N,Z,C,V} status word
    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

endpackage

// File: rtl/alu_issue_regfile.sv
// rtl/alu_issue_regfile.sv - NREGS x NBits register file, two read ports, writeback-over-load write
module alu_issue_regfile #(
    parameter int NBits = 8,
    parameter int NREGS = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [$clog2(NREGS)-1:0] ra_addr,
    output logic [NBits-1:0]         ra_data,
    input  logic [$clog2(NREGS)-1:0] rb_addr,
    output logic [NBits-1:0]         rb_data,
    input  logic                     wb_en,
    input  logic [$clog2(NREGS)-1:0] wb_addr,
    input  logic [NBits-1:0]         wb_data,
    input  logic                     ld_en,
    input  logic [$clog2(NREGS)-1:0] ld_addr,
    input  logic [NBits-1:0]         ld_data
);
    localparam int AW = $clog2(NREGS);

    logic [NBits-1:0] regs [NREGS];

    assign ra_data = regs[ra_addr];
    assign rb_data = regs[rb_addr];

    // Per-entry write; a writeback to the same entry shadows a concurrent load
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NREGS; i++) begin
                if (wb_en && wb_addr == AW'(i)) begin
                    regs[i] <= wb_data;
                end else if (ld_en && ld_addr == AW'(i)) begin
                    regs[i] <= ld_data;
                end
            end
        end
    end

endmodule

// File: rtl/alu_issue_unit.sv
// rtl/alu_issue_unit.sv - command sequencer driving an external ALU (optional CARRY_CHAIN_EN)
module alu_issue_unit
    import alu_issue_pkg::*;
#(
    parameter int NBits = 8,
    parameter int NREGS = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic [3:0]               cmd_op,
    input  logic                     cmd_use_carry,
    input  logic [$clog2(NREGS)-1:0] cmd_rd,
    input  logic [$clog2(NREGS)-1:0] cmd_ra,
    input  logic [$clog2(NREGS)-1:0] cmd_rb,
    input  logic                     ld_valid,
    input  logic [$clog2(NREGS)-1:0] ld_addr,
    input  logic [NBits-1:0]         ld_data,
    output logic [3:0]               alu_sel,
    output logic [NBits-1:0]         alu_a,
    output logic [NBits-1:0]         alu_b,
    output logic                     alu_cin,
    input  logic [NBits-1:0]         alu_result,
    input  logic                     alu_zero,
    input  logic                     alu_negative,
    input  logic                     alu_overflow,
    input  logic                     alu_carry,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [NBits-1:0]         rsp_result,
    output logic [3:0]               rsp_flags,
    output logic                     rsp_err
);
    localparam int AW = $clog2(NREGS);

    state_t            state;
    logic [AW-1:0]     rd_q;
    logic [3:0]        status_q;
    logic [3:0]        flags_next;
    logic [NBits-1:0]  ra_data;
    logic [NBits-1:0]  rb_data;
    logic              accept;
    logic              legal_op;
    logic              wb_en;
    logic              cin_next;

    assign accept   = cmd_valid & cmd_ready;
    assign legal_op = (cmd_op <= OP_MAX);
    assign wb_en    = (state == S_CAPTURE);

`ifdef CARRY_CHAIN_EN
    assign cin_next = cmd_use_carry & status_q[FLAG_C] & (cmd_op == OP_ADD);
`else
    logic unused_use_carry;
    assign unused_use_carry = cmd_use_carry;
    assign cin_next = 1'b0;
`endif

    alu_issue_regfile #(
        .NBits (NBits),
        .NREGS (NREGS)
    ) u_regfile (
        .clk     (clk),
        .rst_n   (rst_n),
        .ra_addr (cmd_ra),
        .ra_data (ra_data),
        .rb_addr (cmd_rb),
        .rb_data (rb_data),
        .wb_en   (wb_en),
        .wb_addr (rd_q),
        .wb_data (alu_result),
        .ld_en   (ld_valid),
        .ld_addr (ld_addr),
        .ld_data (ld_data)
    );

    // New status: N/Z always follow the ALU, C/V only for add/sub (alu_sel holds the latched op)
    always_comb begin
        flags_next         = status_q;
        flags_next[FLAG_N] = alu_negative;
        flags_next[FLAG_Z] = alu_zero;
        if (alu_sel == OP_ADD || alu_sel == OP_SUB) begin
            flags_next[FLAG_C] = alu_carry;
            flags_next[FLAG_V] = alu_overflow;
        end
    end

    // Issue FSM with registered handshake, ALU drive and response outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            cmd_ready  <= 1'b0;
            rd_q       <= '0;
            status_q   <= '0;
            alu_sel    <= '0;
            alu_a      <= '0;
            alu_b      <= '0;
            alu_cin    <= 1'b0;
            rsp_valid  <= 1'b0;
            rsp_result <= '0;
            rsp_flags  <= '0;
            rsp_err    <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    cmd_ready <= 1'b1;
                    if (accept) begin
                        cmd_ready <= 1'b0;
                        rd_q      <= cmd_rd;
                        if (legal_op) begin
                            alu_sel <= cmd_op;
                            alu_a   <= ra_data;
                            alu_b   <= rb_data;
                            alu_cin <= cin_next;
                            state   <= S_ISSUE;
                        end else begin
                            rsp_valid  <= 1'b1;
                            rsp_err    <= 1'b1;
                            rsp_result <= '0;
                            rsp_flags  <= status_q;
                            state      <= S_RESP;
                        end
                    end
                end
                S_ISSUE: begin
                    state <= S_CAPTURE;
                end
                S_CAPTURE: begin
                    status_q   <= flags_next;
                    rsp_flags  <= flags_next;
                    rsp_result <= alu_result;
                    rsp_err    <= 1'b0;
                    rsp_valid  <= 1'b1;
                    state      <= S_RESP;
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        cmd_ready <= 1'b1;
                        state     <= S_IDLE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_issue_unit.sv
// tb/tb_alu_issue_unit.sv - self-checking bench for alu_issue_unit with an attached ALU model
module tb_alu_issue_unit;

    logic       clk;
    logic       rst_n;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [3:0] cmd_op;
    logic       cmd_use_carry;
    logic [1:0] cmd_rd;
    logic [1:0] cmd_ra;
    logic [1:0] cmd_rb;
    logic       ld_valid;
    logic [1:0] ld_addr;
    logic [7:0] ld_data;
    logic [3:0] alu_sel;
    logic [7:0] alu_a;
    logic [7:0] alu_b;
    logic       alu_cin;
    logic [7:0] alu_result;
    logic       alu_zero;
    logic       alu_negative;
    logic       alu_overflow;
    logic       alu_carry;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [7:0] rsp_result;
    logic [3:0] rsp_flags;
    logic       rsp_err;

    int checks = 0;
    int errors = 0;

    logic [7:0] regs_m [4];
    logic [3:0] status_m;

    alu_issue_unit #(.NBits(8), .NREGS(4)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .cmd_op        (cmd_op),
        .cmd_use_carry (cmd_use_carry),
        .cmd_rd        (cmd_rd),
        .cmd_ra        (cmd_ra),
        .cmd_rb        (cmd_rb),
        .ld_valid      (ld_valid),
        .ld_addr       (ld_addr),
        .ld_data       (ld_data),
        .alu_sel       (alu_sel),
        .alu_a         (alu_a),
        .alu_b         (alu_b),
        .alu_cin       (alu_cin),
        .alu_result    (alu_result),
        .alu_zero      (alu_zero),
        .alu_negative  (alu_negative),
        .alu_overflow  (alu_overflow),
        .alu_carry     (alu_carry),
        .rsp_valid     (rsp_valid),
        .rsp_ready     (rsp_ready),
        .rsp_result    (rsp_result),
        .rsp_flags     (rsp_flags),
        .rsp_err       (rsp_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    // 8-bit ALU behaviour: returns {result, N, Z, C, V}; sub carry means borrow
    function automatic logic [11:0] alu_fn(input logic [3:0] op, input logic [7:0] a,
                                           input logic [7:0] b, input logic cin);
        logic [7:0] r;
        logic       c;
        logic       v;
        r = 8'h00;
        c = 1'b0;
        v = 1'b0;
        case (op)
            4'd0: begin
                {c, r} = {1'b0, a} + {1'b0, b} + {8'h00, cin};
                v = (a[7] == b[7]) && (r[7] != a[7]);
            end
            4'd1: begin
                {c, r} = {1'b0, a} - {1'b0, b};
                v = (a[7] != b[7]) && (r[7] != a[7]);
            end
            4'd2: r = a & b;
            4'd3: r = a | b;
            4'd4: r = ~a;
            4'd5: r = a ^ b;
            4'd6: r = a << b[2:0];
            4'd7: r = a >> b[2:0];
            4'd8: r = 8'($signed(a) >>> b[2:0]);
            default: r = 8'h00;
        endcase
        return {r, r[7], (r == 8'h00), c, v};
    endfunction

    assign {alu_result, alu_negative, alu_zero, alu_carry, alu_overflow} =
        alu_fn(alu_sel, alu_a, alu_b, alu_cin);

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic load(input int addr, input logic [7:0] data);
        @(negedge clk);
        ld_valid = 1'b1;
        ld_addr  = addr[1:0];
        ld_data  = data;
        @(negedge clk);
        ld_valid = 1'b0;
        regs_m[addr] = data;
    endtask

    // One full command; hold = cycles of rsp back-pressure, offer = present an
    // illegal command during back-pressure and leave it asserted afterwards
    task automatic do_op(input logic [3:0] op, input int rd, input int ra, input int rb,
                         input bit uc, input int hold, input bit collide, input bit offer);
        logic [7:0]  a;
        logic [7:0]  b;
        logic [7:0]  er;
        logic [3:0]  ef;
        logic [11:0] r;
        logic        cin;
        bit          legal;
        int          n;
        legal = (op <= 4'd8);
        a = regs_m[ra];
        b = regs_m[rb];
`ifdef CARRY_CHAIN_EN
        cin = uc && (op == 4'd0) && status_m[1];
`else
        cin = 1'b0;
`endif
        r = alu_fn(op, a, b, cin);
        if (legal) begin
            er = r[11:4];
            ef = {r[3], r[2], (op <= 4'd1) ? r[1] : status_m[1], (op <= 4'd1) ? r[0] : status_m[0]};
        end else begin
            er = 8'h00;
            ef = status_m;
        end
        @(negedge clk);
        check("cmd_ready_idle", cmd_ready, 1);
        cmd_valid     = 1'b1;
        cmd_op        = op;
        cmd_use_carry = uc;
        cmd_rd        = rd[1:0];
        cmd_ra        = ra[1:0];
        cmd_rb        = rb[1:0];
        @(negedge clk);
        cmd_valid = 1'b0;
        n = 1;
        if (legal) begin
            check("alu_sel", alu_sel, op);
            check("alu_a", alu_a, a);
            check("alu_b", alu_b, b);
            check("alu_cin", alu_cin, cin);
        end
        while (!rsp_valid && n < 8) begin
            if (collide && n == 2) begin
                ld_valid = 1'b1;
                ld_addr  = rd[1:0];
                ld_data  = ~er;
            end
            @(negedge clk);
            ld_valid = 1'b0;
            n++;
        end
        check("latency", n, legal ? 3 : 1);
        check("rsp_valid", rsp_valid, 1);
        check("rsp_result", rsp_result, er);
        check("rsp_flags", rsp_flags, ef);
        check("rsp_err", rsp_err, !legal);
        check("cmd_ready_busy", cmd_ready, 0);
        if (offer) begin
            cmd_valid = 1'b1;
            cmd_op    = 4'hF;
        end
        for (int k = 0; k < hold; k++) begin
            @(negedge clk);
            check("hold_valid", rsp_valid, 1);
            check("hold_result", rsp_result, er);
            check("hold_flags", rsp_flags, ef);
            check("hold_ready", cmd_ready, 0);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        check("rsp_drop", rsp_valid, 0);
        if (legal) begin
            regs_m[rd] = er;
            status_m   = ef;
        end
    endtask

    initial begin
        rst_n = 1'b0;
        cmd_valid = 1'b0;
        cmd_op = 4'h0;
        cmd_use_carry = 1'b0;
        cmd_rd = 2'd0;
        cmd_ra = 2'd0;
        cmd_rb = 2'd0;
        ld_valid = 1'b0;
        ld_addr = 2'd0;
        ld_data = 8'h00;
        rsp_ready = 1'b0;
        for (int i = 0; i < 4; i++) regs_m[i] = 8'h00;
        status_m = 4'h0;

        // reset state
        repeat (2) @(negedge clk);
        check("rst_cmd_ready", cmd_ready, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_result", rsp_result, 0);
        check("rst_rsp_flags", rsp_flags, 0);
        check("rst_rsp_err", rsp_err, 0);
        check("rst_alu", {alu_sel, alu_a, alu_b, alu_cin}, 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("ready_after_rst", cmd_ready, 1);

        // add 0x7F + 0x01
        load(0, 8'h7F);
        load(1, 8'h01);
        do_op(4'd0, 2, 0, 1, 1'b0, 0, 1'b0, 1'b0);
        do_op(4'd3, 2, 2, 2, 1'b0, 0, 1'b0, 1'b0);

        // sub to zero, then and keeps C/V
        load(0, 8'h05);
        load(1, 8'h05);
        do_op(4'd1, 3, 0, 1, 1'b0, 0, 1'b0, 1'b0);
        do_op(4'd2, 3, 0, 1, 1'b0, 0, 1'b0, 1'b0);

        // carry chain
        load(0, 8'hFF);
        load(1, 8'h01);
        do_op(4'd0, 2, 0, 1, 1'b0, 0, 1'b0, 1'b0);
        load(0, 8'h00);
        load(1, 8'h00);
        do_op(4'd0, 3, 0, 1, 1'b1, 0, 1'b0, 1'b0);

        // illegal opcode, then readback of rd proves no write
        do_op(4'hC, 1, 0, 1, 1'b0, 0, 1'b0, 1'b0);
        do_op(4'd3, 1, 1, 1, 1'b0, 0, 1'b0, 1'b0);

        // back-pressure with a command offered meanwhile
        do_op(4'd5, 0, 2, 3, 1'b0, 4, 1'b0, 1'b1);
        check("offer_ready", cmd_ready, 1);
        check("offer_not_taken", rsp_valid, 0);
        @(negedge clk);
        cmd_valid = 1'b0;
        check("offer_rsp_valid", rsp_valid, 1);
        check("offer_rsp_err", rsp_err, 1);
        check("offer_flags", rsp_flags, status_m);
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;

        // writeback wins over a colliding load
        load(0, 8'h21);
        load(1, 8'h13);
        do_op(4'd0, 2, 0, 1, 1'b0, 0, 1'b1, 1'b0);
        do_op(4'd3, 2, 2, 2, 1'b0, 0, 1'b0, 1'b0);

        // randomized traffic
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                load(int'($urandom_range(0, 3)), 8'($urandom));
            end else begin
                do_op(($urandom_range(0, 7) == 0) ? 4'($urandom_range(9, 15)) : 4'($urandom_range(0, 8)),
                      int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                      1'($urandom_range(0, 1)), int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)), 1'b0);
            end
        end

        // reset during CAPTURE
        load(0, 8'h03);
        load(1, 8'h04);
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_op = 4'd0;
        cmd_rd = 2'd1;
        cmd_ra = 2'd0;
        cmd_rb = 2'd1;
        @(negedge clk);
        cmd_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_rsp_valid", rsp_valid, 0);
        check("midrst_cmd_ready", cmd_ready, 0);
        check("midrst_alu", {alu_sel, alu_a, alu_b, alu_cin}, 0);
        check("midrst_rsp", {rsp_result, rsp_flags, rsp_err}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) regs_m[i] = 8'h00;
        status_m = 4'h0;
        @(negedge clk);
        do_op(4'd3, 1, 1, 1, 1'b0, 0, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_issue_unit.md
Name: alu_issue_unit

Overview:
- Sequencing front-end that drives the team's combinational N-bit ALU.
- Accepts register-addressed operation commands over a valid/ready handshake.
- Reads operands from a small internal register file, drives ALU selection/operands/carry_in, and samples the result and flags.
- Writes the result back, keeps an NZCV status register, and returns a response over a second valid/ready handshake.

Parameters:
- NBits, 8, datapath width; must match the attached ALU.
- NREGS, 4, register-file depth; power of two, at least 2.

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- rst_n  input  1  reset; asynchronous assert, active-low.
- cmd_valid  input  1  command offered.
- cmd_ready  output  1  unit can accept a command.
- cmd_op  input  4  ALU selection code: 0 add, 1 sub, 2 and, 3 or, 4 not, 5 xor, 6 shl, 7 shr, 8 sra.
- cmd_use_carry  input  1  add with stored C flag (ADC).
- cmd_rd, cmd_ra, cmd_rb  input  $clog2(NREGS) each  destination and source register indices.
- ld_valid  input  1  direct register load.
- ld_addr  input  $clog2(NREGS)  register index for the load.
- ld_data  input  NBits  value for the load.
- alu_sel  output  4  to ALU selection.
- alu_a, alu_b  output  NBits  to ALU A and B.
- alu_cin  output  1  to ALU carry_in.
- alu_result  input  NBits  from ALU result.
- alu_zero, alu_negative, alu_overflow, alu_carry  input  1 each  from ALU flags.
- rsp_valid  output  1  response available.
- rsp_ready  input  1  response consumed.
- rsp_result  output  NBits  captured result.
- rsp_flags  output  4  {N,Z,C,V} after the operation.
- rsp_err  output  1  illegal opcode (9..15).

Behaviour:
- Reset: state IDLE. cmd_ready=0 while rst_n is low, 1 after release. rsp_valid=0, rsp_result=0, rsp_flags=0, rsp_err=0. alu_sel/alu_a/alu_b/alu_cin=0. Register file=0, status NZCV=0.
- Reset mid-operation aborts the operation. No writeback occurs after reset.
- FSM states: IDLE, ISSUE, CAPTURE, RESP.
- IDLE: cmd_ready=1. On cmd_valid&cmd_ready, latch op, rd, use_carry and regs[ra]/regs[rb] (values as read in that cycle).
  - Legal op: go to ISSUE.
  - Illegal op: go to RESP with rsp_err=1, rsp_result=0, flags unchanged, no ALU drive.
- ISSUE: registered alu_sel/alu_a/alu_b/alu_cin present the latched values. go to CAPTURE.
- CAPTURE: ALU outputs held stable. Sample alu_result and flags, write regs[rd]=alu_result, update status. go to RESP.
- RESP: rsp_valid=1; rsp_* held stable until rsp_ready. On handshake, go to IDLE. cmd_ready=0 in all states except IDLE.
- Latency: accept at cycle T, rsp_valid at T+3. Illegal op: rsp_valid at T+1.
- Flag rules:
  - N and Z updated for every legal op.
  - C and V updated only for op 0/1; retained for all other ops.
- ALU drive lines hold their last values outside ISSUE/CAPTURE.
- Load port accepted in any state. On a same-cycle same-address collision with the CAPTURE writeback, the writeback wins and the load is dropped.
- rd equal to ra/rb is legal; operands were already latched at accept.

Optional Feature:
- CARRY_CHAIN_EN defined: alu_cin = cmd_use_carry & C for op 0; alu_cin=0 for all other ops.
- Not defined: cmd_use_carry is ignored and alu_cin is constant 0.

Decomposition:
- Package alu_issue_pkg:
  - state enum;
  - opcode localparams OP_ADD..OP_SRA;
  - OP_MAX=8;
  - flag bit-index constants FLAG_N/Z/C/V.
- Sub-module alu_issue_regfile: NREGS x NBits, two combinational read ports, one write port with writeback-over-load priority.
- FSM, handshakes and status register stay in the top.

Test Plan (NBits=8, ALU attached):
- Load r0=0x7F, r1=0x01, then add r2=r0+r1 → rsp at T+3, rsp_result=0x80, N=1 Z=0 V=1, C=alu_carry sample; regs[2]=0x80.
- Load r0=0x05, r1=0x05, then sub r3=r0-r1 → rsp_result=0x00, Z=1, N=0; then and r3=r0&r1 → 0x05, C and V unchanged from the sub.
- CARRY_CHAIN_EN defined: 0xFF+0x01 → 0x00, C=1, Z=1; then ADC 0x00+0x00 → 0x01, C=0. Macro undefined: second op → 0x00.
- cmd_op=0xC → rsp_valid at T+1, rsp_err=1, flags unchanged, no regfile write.
- Hold rsp_ready=0 for 4 cycles → rsp_valid, rsp_result and rsp_flags stable, cmd_ready=0. A cmd_valid offered meanwhile is not accepted until one cycle after the rsp handshake.
- Deassert rst_n during CAPTURE → all outputs zero immediately, regs[rd] not written.
- Collision: ld_valid targets rd in the CAPTURE cycle → regs[rd]=alu_result.
